trap_sched: RTL and testbench

TRAP_SCHED -- requirements
Module: trap_sched

---
 rtl/trap_sched_pkg.sv | 23 ++
 rtl/trap_vec_calc.sv | 31 +++
 rtl/trap_sched.sv | 167 ++++++++++++++++
 tb/tb_trap_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_sched_pkg.sv
// Shared constants and types for the trap scheduler: FSM states, event kinds,
// mcause codes and the mtvec vectored-mode encoding.
package trap_sched_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrain  = 2'd1,
    StCommit = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KindExc  = 2'd0,
    KindInt  = 2'd1,
    KindMret = 2'd2
  } kind_e;

  localparam int unsigned CauseBreakpoint = 3;
  localparam int unsigned CauseEcallM     = 11;
  localparam int unsigned CauseMTimer     = 7;

  localparam logic [1:0] MtvecModeVectored = 2'b01;

endpackage

// File: rtl/trap_vec_calc.sv
// Redirect target for a detected event: mepc for MRET, otherwise the mtvec base,
// offset by 4*cause for timer interrupts in vectored mode.
module trap_vec_calc
  import trap_sched_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter bit          VECTORED_EN = 1'b0
) (
  input  kind_e            kind_i,
  input  logic [XLEN-1:0]  mtvec_i,
  input  logic [XLEN-1:0]  mepc_i,
  output logic [XLEN-1:0]  target_o
);

  logic [XLEN-1:0] base;

  always_comb begin
    base     = {mtvec_i[XLEN-1:2], 2'b00};
    target_o = base;
    unique case (kind_i)
      KindMret: target_o = mepc_i;
      KindInt: begin
        if (VECTORED_EN && (mtvec_i[1:0] == MtvecModeVectored)) begin
          target_o = base + XLEN'(4 * CauseMTimer);
        end
      end
      default: target_o = base;
    endcase
  end

endmodule

// File: rtl/trap_sched.sv
// Trap/MRET scheduler: detects a retiring event, waits for the bus to drain
// (bounded by DRAIN_TO), then emits one commit cycle of strobes and a redirect.
module trap_sched
  import trap_sched_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter bit          VECTORED_EN = 1'b0,
  parameter int unsigned DRAIN_TO    = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic [XLEN-1:0]  wb_npc,
  input  logic             wb_ecall,
  input  logic             wb_ebreak,
  input  logic             wb_mret,
  input  logic             mstatus_mie,
  input  logic             mie_mtie,
  input  logic             clint_mtip,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  mepc,
  input  logic             bus_busy,
  output logic             stall,
  output logic             trap_req,
  output logic             ret_req,
  output logic [XLEN-1:0]  trap_cause,
  output logic [XLEN-1:0]  trap_epc,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             drain_err,
  output logic [31:0]      trap_cnt
);

  localparam int unsigned CntW = $clog2(DRAIN_TO + 1);

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d, det_kind;
  logic            detect, irq_pend;
  logic [XLEN-1:0] det_cause, det_epc, det_target;
  logic [XLEN-1:0] cause_q, cause_d, epc_q, epc_d, target_q, target_d;
  logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
  logic [31:0]     cnt_q, cnt_d;

  assign irq_pend = clint_mtip & mie_mtie & mstatus_mie;

  // Priority decode; an interrupt loses to any retiring MRET or exception.
  always_comb begin
    detect    = 1'b0;
    det_kind  = KindExc;
    det_cause = '0;
    det_epc   = wb_pc;
    if (state_q == StIdle && wb_valid) begin
      if (wb_ebreak) begin
        detect    = 1'b1;
        det_cause = XLEN'(CauseBreakpoint);
      end else if (wb_ecall) begin
        detect    = 1'b1;
        det_cause = XLEN'(CauseEcallM);
      end else if (wb_mret) begin
        detect   = 1'b1;
        det_kind = KindMret;
      end else if (irq_pend) begin
        detect    = 1'b1;
        det_kind  = KindInt;
        det_cause = {1'b1, (XLEN-1)'(CauseMTimer)};
        det_epc   = wb_npc;
      end
    end
  end

  trap_vec_calc #(
    .XLEN        (XLEN),
    .VECTORED_EN (VECTORED_EN)
  ) u_vec_calc (
    .kind_i   (det_kind),
    .mtvec_i  (mtvec),
    .mepc_i   (mepc),
    .target_o (det_target)
  );

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    cause_d        = cause_q;
    epc_d          = epc_q;
    target_d       = target_q;
    drain_cnt_d    = drain_cnt_q;
    cnt_d          = cnt_q;
    stall          = 1'b0;
    trap_req       = 1'b0;
    ret_req        = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    drain_err      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (detect) begin
          stall       = 1'b1;
          kind_d      = det_kind;
          target_d    = det_target;
          drain_cnt_d = '0;
          if (det_kind != KindMret) begin
            cause_d = det_cause;
            epc_d   = det_epc;
          end
          if (bus_busy) begin
            state_d = StDrain;
          end else begin
            state_d = StCommit;
            if (det_kind != KindMret) cnt_d = cnt_q + 32'd1;
          end
        end
      end
      StDrain: begin
        stall = 1'b1;
        if (!bus_busy) begin
          state_d = StCommit;
        end else if (drain_cnt_q == CntW'(DRAIN_TO - 1)) begin
          drain_err = 1'b1;
          state_d   = StCommit;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
        // Count on COMMIT entry so trap_cnt already reflects the trap during COMMIT.
        if (state_d == StCommit && kind_q != KindMret) cnt_d = cnt_q + 32'd1;
      end
      StCommit: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        flush          = 1'b1;
        drain_cnt_d    = '0;
        if (kind_q == KindMret) ret_req = 1'b1;
        else                    trap_req = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      kind_q      <= KindExc;
      cause_q     <= '0;
      epc_q       <= '0;
      target_q    <= '0;
      drain_cnt_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      target_q    <= target_d;
      drain_cnt_q <= drain_cnt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign trap_cause  = cause_q;
  assign trap_epc    = epc_q;
  assign redirect_pc = target_q;
  assign trap_cnt    = cnt_q;

endmodule

// File: tb/tb_trap_sched.sv
// Scenario bench for trap_sched: expected commits are queued when an event is
// driven and popped when the DUT raises trap_req/ret_req.
module tb_trap_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ecall, wb_ebreak, wb_mret;
  logic [63:0] wb_pc, wb_npc, mtvec, mepc;
  logic        mstatus_mie, mie_mtie, clint_mtip, bus_busy;
  logic        stall, trap_req, ret_req, redirect_valid, flush, drain_err;
  logic [63:0] trap_cause, trap_epc, redirect_pc;
  logic [31:0] trap_cnt;

  always #5 clk = ~clk;

  trap_sched #(
    .XLEN        (64),
    .VECTORED_EN (1'b1),
    .DRAIN_TO    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_npc         (wb_npc),
    .wb_ecall       (wb_ecall),
    .wb_ebreak      (wb_ebreak),
    .wb_mret        (wb_mret),
    .mstatus_mie    (mstatus_mie),
    .mie_mtie       (mie_mtie),
    .clint_mtip     (clint_mtip),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .bus_busy       (bus_busy),
    .stall          (stall),
    .trap_req       (trap_req),
    .ret_req        (ret_req),
    .trap_cause     (trap_cause),
    .trap_epc       (trap_epc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .drain_err      (drain_err),
    .trap_cnt       (trap_cnt)
  );

  typedef struct packed {
    logic        ret;
    logic [63:0] cause;
    logic [63:0] epc;
    logic [63:0] target;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [63:0] IrqCause = {1'b1, 63'd7};

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  task automatic clear_in();
    wb_valid = 1'b0; wb_ecall = 1'b0; wb_ebreak = 1'b0; wb_mret = 1'b0;
    clint_mtip = 1'b0; mie_mtie = 1'b0; mstatus_mie = 1'b0; bus_busy = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic ret, input logic [63:0] cause, input logic [63:0] epc,
                          input logic [63:0] target);
    if (!ret) exp_cnt++;
    sb_q.push_back({ret, cause, epc, target, 32'(exp_cnt)});
  endtask

  task automatic wait_commit(input int budget, output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (trap_req || ret_req) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_in();
    wb_pc = '0; wb_npc = '0; mtvec = '0; mepc = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({stall, trap_req, ret_req, redirect_valid, flush, drain_err} !== 6'b0) begin
      n_err++; $display("FAIL reset_strobes got=%b exp=000000",
                        {stall, trap_req, ret_req, redirect_valid, flush, drain_err});
    end
    n_cmp++; if (trap_cause !== 64'd0) begin
      n_err++; $display("FAIL reset_cause got=%h exp=0", trap_cause); end
    n_cmp++; if (trap_epc !== 64'd0) begin
      n_err++; $display("FAIL reset_epc got=%h exp=0", trap_epc); end
    n_cmp++; if (redirect_pc !== 64'd0) begin
      n_err++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
    n_cmp++; if (trap_cnt !== 32'd0) begin
      n_err++; $display("FAIL reset_trap_cnt got=%0d exp=0", trap_cnt); end
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic test_ecall();
    int lat; bit seen; exp_t e;
    mtvec = 64'h8000_0000;
    next_cyc();
    wb_valid = 1'b1; wb_ecall = 1'b1; wb_pc = 64'h8000_0100; wb_npc = 64'h8000_0104;
    push_exp(1'b0, 64'd11, 64'h8000_0100, 64'h8000_0000);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1 || trap_req !== 1'b0) begin
      n_err++; $display("FAIL ecall_detect stall/trap_req got=%b%b exp=10", stall, trap_req); end
    next_cyc();
    clear_in();
    wait_commit(8, lat, seen);
    e = sb_q.pop_front();
    n_cmp++; if (!seen || lat != 1) begin
      n_err++; $display("FAIL ecall_latency seen=%0d got=%0d exp=1", seen, lat); end
    n_cmp++; if (trap_req !== 1'b1 || ret_req !== 1'b0 || redirect_valid !== 1'b1
                 || flush !== 1'b1) begin
      n_err++; $display("FAIL ecall_strobes trap/ret/rv/flush got=%b%b%b%b exp=1011",
                        trap_req, ret_req, redirect_valid, flush);
    end
    n_cmp++; if (trap_cause !== e.cause) begin
      n_err++; $display("FAIL ecall_cause got=%h exp=%h", trap_cause, e.cause); end
    n_cmp++; if (trap_epc !== e.epc) begin
      n_err++; $display("FAIL ecall_epc got=%h exp=%h", trap_epc, e.epc); end
    n_cmp++; if (redirect_pc !== e.target) begin
      n_err++; $display("FAIL ecall_redirect got=%h exp=%h", redirect_pc, e.target); end
    n_cmp++; if (trap_cnt !== e.cnt) begin
      n_err++; $display("FAIL ecall_trap_cnt got=%0d exp=%0d", trap_cnt, e.cnt); end
    next_cyc();
    @(negedge clk);
    n_cmp++; if ({stall, trap_req, redirect_valid, flush} !== 4'b0) begin
      n_err++; $display("FAIL ecall_after got=%b exp=0000",
                        {stall, trap_req, redirect_valid, flush});
    end
  endtask

  task automatic test_irq_vectored();
    int lat; bit seen; exp_t e;
    mtvec = 64'h8000_0001;
    next_cyc();
    wb_valid = 1'b1; wb_pc = 64'h8000_0200; wb_npc = 64'h8000_0204;
    clint_mtip = 1'b1; mie_mtie = 1'b1; mstatus_mie = 1'b1;
    push_exp(1'b0, IrqCause, 64'h8000_0204, 64'h8000_001C);
    @(negedge clk);
    next_cyc();
    clear_in();
    wait_commit(8, lat, seen);
    e = sb_q.pop_front();
    n_cmp++; if (!seen || trap_req !== 1'b1) begin
      n_err++; $display("FAIL irq_commit seen=%0d trap_req got=%b exp=1", seen, trap_req); end
    n_cmp++; if (trap_cause !== e.cause) begin
      n_err++; $display("FAIL irq_cause got=%h exp=%h", trap_cause, e.cause); end
    n_cmp++; if (trap_epc !== e.epc) begin
      n_err++; $display("FAIL irq_epc got=%h exp=%h", trap_epc, e.epc); end
    n_cmp++; if (redirect_pc !== e.target) begin
      n_err++; $display("FAIL irq_vector_target got=%h exp=%h", redirect_pc, e.target); end
    n_cmp++; if (trap_cnt !== e.cnt) begin
      n_err++; $display("FAIL irq_trap_cnt got=%0d exp=%0d", trap_cnt, e.cnt); end
  endtask

  task automatic test_mret_irq();
    int lat; bit seen; exp_t e; int strobes;
    mtvec = 64'h8000_0000; mepc = 64'h8000_0300;
    next_cyc();
    wb_valid = 1'b1; wb_mret = 1'b1; wb_pc = 64'h8000_0400; wb_npc = 64'h8000_0404;
    clint_mtip = 1'b1; mie_mtie = 1'b1; mstatus_mie = 1'b1;
    push_exp(1'b1, 64'd0, 64'd0, 64'h8000_0300);
    @(negedge clk);
    next_cyc();
    wb_valid = 1'b0; wb_mret = 1'b0;
    wait_commit(8, lat, seen);
    e = sb_q.pop_front();
    n_cmp++; if (!seen || ret_req !== 1'b1 || trap_req !== 1'b0) begin
      n_err++; $display("FAIL mret_strobe seen=%0d ret/trap got=%b%b exp=10",
                        seen, ret_req, trap_req);
    end
    n_cmp++; if (redirect_pc !== e.target) begin
      n_err++; $display("FAIL mret_redirect got=%h exp=%h", redirect_pc, e.target); end
    n_cmp++; if (trap_cnt !== e.cnt) begin
      n_err++; $display("FAIL mret_trap_cnt got=%0d exp=%0d", trap_cnt, e.cnt); end
    // Interrupt still pending but nothing retires: no event may be taken.
    strobes = 0;
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      @(negedge clk);
      strobes += int'(stall) + int'(trap_req);
    end
    n_cmp++; if (strobes != 0) begin
      n_err++; $display("FAIL irq_no_valid stall+trap cycles got=%0d exp=0", strobes); end
    next_cyc();
    wb_valid = 1'b1; wb_pc = 64'h8000_0300; wb_npc = 64'h8000_0304;
    push_exp(1'b0, IrqCause, 64'h8000_0304, 64'h8000_0000);
    @(negedge clk);
    next_cyc();
    clear_in();
    wait_commit(8, lat, seen);
    e = sb_q.pop_front();
    n_cmp++; if (!seen || trap_req !== 1'b1 || trap_cause !== e.cause) begin
      n_err++; $display("FAIL deferred_irq seen=%0d cause got=%h exp=%h", seen, trap_cause,
                        e.cause);
    end
    n_cmp++; if (trap_epc !== e.epc || redirect_pc !== e.target) begin
      n_err++; $display("FAIL deferred_irq_pc epc=%h/%h redirect=%h/%h", trap_epc, e.epc,
                        redirect_pc, e.target);
    end
    n_cmp++; if (trap_cnt !== e.cnt) begin
      n_err++; $display("FAIL deferred_irq_cnt got=%0d exp=%0d", trap_cnt, e.cnt); end
  endtask

  task automatic test_ebreak_drain();
    int stalls = 0, errs = 0, commits = 0, commit_c = 0; exp_t e;
    mtvec = 64'h8000_0041;
    // Bus already busy one cycle before the EBREAK retires; busy for 5 cycles total.
    for (int c = 1; c <= 12; c++) begin
      next_cyc();
      clear_in();
      bus_busy  = (c <= 5);
      wb_valid  = (c == 2) || (c == 4);
      wb_ebreak = (c == 2);
      wb_ecall  = (c == 4);
      wb_pc     = 64'h8000_0500;
      if (c == 2) push_exp(1'b0, 64'd3, 64'h8000_0500, 64'h8000_0040);
      @(negedge clk);
      stalls += int'(stall);
      errs   += int'(drain_err);
      if (trap_req || ret_req) begin
        commits++;
        commit_c = c;
        if (commits == 1) begin
          e = sb_q.pop_front();
          n_cmp++; if (trap_cause !== e.cause || trap_epc !== e.epc) begin
            n_err++; $display("FAIL ebreak_cause_epc got=%h/%h exp=%h/%h", trap_cause,
                              trap_epc, e.cause, e.epc);
          end
          n_cmp++; if (redirect_pc !== e.target || trap_cnt !== e.cnt) begin
            n_err++; $display("FAIL ebreak_target_cnt got=%h/%0d exp=%h/%0d", redirect_pc,
                              trap_cnt, e.target, e.cnt);
          end
        end
      end
    end
    n_cmp++; if (stalls != 6) begin
      n_err++; $display("FAIL ebreak_stall_cycles got=%0d exp=6", stalls); end
    n_cmp++; if (commit_c != 7) begin
      n_err++; $display("FAIL ebreak_commit_cycle got=%0d exp=7", commit_c); end
    n_cmp++; if (commits != 1) begin
      n_err++; $display("FAIL ebreak_commit_count got=%0d exp=1", commits); end
    n_cmp++; if (errs != 0) begin
      n_err++; $display("FAIL ebreak_drain_err got=%0d exp=0", errs); end
  endtask

  task automatic test_drain_timeout();
    int errs = 0, err_c = 0, commits = 0, commit_c = 0; exp_t e;
    mtvec = 64'h8000_0000;
    for (int c = 1; c <= 10; c++) begin
      next_cyc();
      clear_in();
      bus_busy = 1'b1;
      wb_valid = (c == 1);
      wb_ecall = (c == 1);
      wb_pc    = 64'h8000_0600;
      if (c == 1) push_exp(1'b0, 64'd11, 64'h8000_0600, 64'h8000_0000);
      @(negedge clk);
      if (drain_err) begin errs++; err_c = c; end
      if (trap_req || ret_req) begin
        commits++;
        commit_c = c;
        if (commits == 1) begin
          e = sb_q.pop_front();
          n_cmp++; if (trap_cause !== e.cause || trap_cnt !== e.cnt) begin
            n_err++; $display("FAIL timeout_cause_cnt got=%h/%0d exp=%h/%0d", trap_cause,
                              trap_cnt, e.cause, e.cnt);
          end
        end
      end
    end
    clear_in();
    n_cmp++; if (errs != 1 || err_c != 5) begin
      n_err++; $display("FAIL timeout_drain_err pulses=%0d cycle=%0d exp=1/5", errs, err_c); end
    n_cmp++; if (commits != 1 || commit_c != 6) begin
      n_err++; $display("FAIL timeout_commit count=%0d cycle=%0d exp=1/6", commits, commit_c);
    end
  endtask

  task automatic test_reset_mid_drain();
    int strobes = 0;
    for (int c = 1; c <= 3; c++) begin
      next_cyc();
      clear_in();
      bus_busy = 1'b1;
      wb_valid = (c == 1);
      wb_ecall = (c == 1);
      wb_pc    = 64'h8000_0700;
      @(negedge clk);
    end
    n_cmp++; if (stall !== 1'b1) begin
      n_err++; $display("FAIL rst_pre_drain stall got=%b exp=1", stall); end
    rst = 1'b1;
    exp_cnt = 0;
    #1;
    n_cmp++; if ({stall, trap_req, ret_req, redirect_valid, flush, drain_err} !== 6'b0) begin
      n_err++; $display("FAIL rst_mid_drain_strobes got=%b exp=000000",
                        {stall, trap_req, ret_req, redirect_valid, flush, drain_err});
    end
    n_cmp++; if (trap_cause !== 64'd0 || trap_epc !== 64'd0 || redirect_pc !== 64'd0
                 || trap_cnt !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_drain_data cause=%h epc=%h pc=%h cnt=%0d exp=0",
                        trap_cause, trap_epc, redirect_pc, trap_cnt);
    end
    next_cyc();
    rst = 1'b0;
    bus_busy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      next_cyc();
      @(negedge clk);
      strobes += int'(trap_req) + int'(ret_req) + int'(stall);
    end
    n_cmp++; if (strobes != 0) begin
      n_err++; $display("FAIL rst_no_late_trap got=%0d exp=0", strobes); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ecall();
    test_irq_vectored();
    test_mret_irq();
    test_ebreak_drain();
    test_drain_timeout();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
